varredura_matriz: RTL and testbench

Column-scan driver for the 7x5 LED matrix. It sits directly downstream of the game selector and consumes its five 7-bit column patterns. It time-multiplexes the patterns onto one shared 7-bit row bus and a one-hot column select. The block double-buffers the patterns at frame boundaries and inserts a blanking interval before each column slot to prevent ghosting.

---
 rtl/varredura_matriz.sv | 140 ++++++++++++++
 tb/tb_varredura_matriz.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/varredura_matriz.sv
// Column-scan driver for the 7x5 LED matrix: double-buffers the five column
// patterns at frame boundaries and blanks the outputs at the start of each slot.
module varredura_matriz #(
  parameter int DIV_CICLOS   = 50000,
  parameter int BLANK_CICLOS = 500
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [6:0] coluna1,
  input  logic [6:0] coluna2,
  input  logic [6:0] coluna3,
  input  logic [6:0] coluna4,
  input  logic [6:0] coluna5,
  output logic [6:0] linhas,
  output logic [4:0] colunas,
  output logic       frame_tick
);

  localparam logic [15:0] CNT_MAX   = 16'(DIV_CICLOS - 1);
  localparam logic [15:0] CNT_BLANK = 16'(BLANK_CICLOS);
  localparam logic [6:0]  DARK      = 7'b1111111;
  localparam logic [2:0]  IDX_LAST  = 3'd4;

  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic [6:0]  r_sombra [0:4];
  logic [6:0]  r_linhas;
  logic [4:0]  r_colunas;
  logic        r_frame_tick;

  logic [15:0] w_cnt_nxt;
  logic [2:0]  w_idx_nxt;
  logic        w_ultimo;
  logic        w_latch;
  logic [6:0]  w_sombra_sel;
  logic [6:0]  w_linhas_nxt;
  logic [4:0]  w_colunas_nxt;

  function automatic logic [4:0] onehot_col(input logic [2:0] idx);
    logic [4:0] sel;
    case (idx)
      3'd0:    sel = 5'b00001;
      3'd1:    sel = 5'b00010;
      3'd2:    sel = 5'b00100;
      3'd3:    sel = 5'b01000;
      3'd4:    sel = 5'b10000;
      default: sel = 5'b00000;
    endcase
    return sel;
  endfunction

  // Slot counter / column index sequencing and frame-latch decode
  always_comb begin
    w_cnt_nxt = 16'd0;
    w_idx_nxt = 3'd0;
    w_ultimo  = (r_cnt >= CNT_MAX);
    w_latch   = en && w_ultimo && (r_idx == IDX_LAST);
    if (!en) begin
      w_cnt_nxt = 16'd0;
      w_idx_nxt = 3'd0;
    end else if (r_idx > IDX_LAST) begin
      w_cnt_nxt = 16'd0;
      w_idx_nxt = 3'd0;
    end else if (w_ultimo) begin
      w_cnt_nxt = 16'd0;
      if (r_idx == IDX_LAST) begin
        w_idx_nxt = 3'd0;
      end else begin
        w_idx_nxt = r_idx + 3'd1;
      end
    end else begin
      w_cnt_nxt = r_cnt + 16'd1;
      w_idx_nxt = r_idx;
    end
  end

  // Shadow pattern for the current column; out-of-range index shows dark
  always_comb begin
    w_sombra_sel = DARK;
    case (r_idx)
      3'd0:    w_sombra_sel = r_sombra[0];
      3'd1:    w_sombra_sel = r_sombra[1];
      3'd2:    w_sombra_sel = r_sombra[2];
      3'd3:    w_sombra_sel = r_sombra[3];
      3'd4:    w_sombra_sel = r_sombra[4];
      default: w_sombra_sel = DARK;
    endcase
  end

  // Next output values: blank phase at slot start, otherwise drive the column
  always_comb begin
    w_linhas_nxt  = DARK;
    w_colunas_nxt = 5'b00000;
    if (!en || (r_cnt < CNT_BLANK)) begin
      w_linhas_nxt  = DARK;
      w_colunas_nxt = 5'b00000;
    end else begin
      w_linhas_nxt  = w_sombra_sel;
      w_colunas_nxt = onehot_col(r_idx);
    end
  end

  // State, shadow buffer and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt        <= 16'd0;
      r_idx        <= 3'd0;
      r_linhas     <= DARK;
      r_colunas    <= 5'b00000;
      r_frame_tick <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        r_sombra[i] <= DARK;
      end
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_linhas     <= w_linhas_nxt;
      r_colunas    <= w_colunas_nxt;
      r_frame_tick <= w_latch;
      // While disabled the shadow tracks the inputs so a restart shows them at once
      if (!en || w_latch) begin
        r_sombra[0] <= coluna1;
        r_sombra[1] <= coluna2;
        r_sombra[2] <= coluna3;
        r_sombra[3] <= coluna4;
        r_sombra[4] <= coluna5;
      end else begin
        for (int i = 0; i < 5; i++) begin
          r_sombra[i] <= r_sombra[i];
        end
      end
    end
  end

  assign linhas     = r_linhas;
  assign colunas    = r_colunas;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_varredura_matriz.sv
// Scoreboard bench for varredura_matriz with DIV_CICLOS=8, BLANK_CICLOS=2.
module tb_varredura_matriz;

  localparam int DIV   = 8;
  localparam int BLANK = 2;

  typedef struct {
    int         edge_no;
    logic [6:0] lin;
    logic [4:0] col;
    logic       tick;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic [6:0] col_in [5];
  logic [6:0] linhas;
  logic [4:0] colunas;
  logic       frame_tick;

  exp_t       sb [$];
  int         edge_cnt = 0;
  int         n_vec = 0;
  int         n_err = 0;

  // Reference model state: edges scanned since (re)start and displayed patterns
  int         m_n = 0;
  logic [6:0] m_sh [5];

  varredura_matriz #(.DIV_CICLOS(DIV), .BLANK_CICLOS(BLANK)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .coluna1    (col_in[0]),
    .coluna2    (col_in[1]),
    .coluna3    (col_in[2]),
    .coluna4    (col_in[3]),
    .coluna5    (col_in[4]),
    .linhas     (linhas),
    .colunas    (colunas),
    .frame_tick (frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Push the expected outputs for the coming edge, then let that edge happen
  task automatic cycle();
    exp_t e;
    int   p;
    int   s;
    e.edge_no = edge_cnt + 1;
    e.lin     = 7'h7F;
    e.col     = 5'b00000;
    e.tick    = 1'b0;
    if (!reset_n) begin
      m_n = 0;
      for (int i = 0; i < 5; i++) m_sh[i] = 7'h7F;
    end else if (!en) begin
      m_n = 0;
      for (int i = 0; i < 5; i++) m_sh[i] = col_in[i];
    end else begin
      p = m_n % DIV;
      s = (m_n / DIV) % 5;
      if (p >= BLANK) begin
        e.col = 5'b00001 << s;
        e.lin = m_sh[s];
      end
      e.tick = (p == DIV - 1) && (s == 4);
      if (e.tick) begin
        for (int i = 0; i < 5; i++) m_sh[i] = col_in[i];
      end
      m_n++;
    end
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Monitor: compare DUT outputs against the entry queued for this edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].edge_no < edge_cnt) begin
        e = sb.pop_front();
        n_vec++;
        n_err++;
        $display("FAIL stale: entry for edge %0d not compared, now edge %0d", e.edge_no, edge_cnt);
      end
      if (sb.size() > 0 && sb[0].edge_no == edge_cnt) begin
        e = sb.pop_front();
        n_vec++;
        if ({linhas, colunas, frame_tick} !== {e.lin, e.col, e.tick}) begin
          n_err++;
          $display("FAIL scan edge %0d: got lin=%b col=%b tick=%b, expected lin=%b col=%b tick=%b",
                   edge_cnt, linhas, colunas, frame_tick, e.lin, e.col, e.tick);
        end
        n_vec++;
        if ($countones(colunas) > 1) begin
          n_err++;
          $display("FAIL onehot edge %0d: got col=%b, expected at most one bit", edge_cnt, colunas);
        end
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    en        = 1'b1;
    col_in[0] = 7'b0111100;
    for (int i = 1; i < 5; i++) col_in[i] = 7'h7F;

    // Reset and first frame
    run(3);
    chk("rst_linhas", 16'(linhas), 16'h007F);
    chk("rst_colunas", 16'(colunas), 16'h0000);
    reset_n = 1'b1;
    run(39);
    chk("tick_edge39", 16'(frame_tick), 16'h0000);
    run(1);
    chk("tick_edge40", 16'(frame_tick), 16'h0001);
    run(3);
    chk("f2_col0_sel", 16'(colunas), 16'h0001);
    chk("f2_col0_lin", 16'(linhas), 16'h003C);

    // Full scan with distinct patterns, latched at edge 80
    col_in[0] = 7'b1111110;
    col_in[1] = 7'b1111101;
    col_in[2] = 7'b1111011;
    col_in[3] = 7'b1110111;
    col_in[4] = 7'b1101111;
    run(37);
    run(12);

    // Mid-frame change of coluna3 while column 2 is lit
    col_in[2] = 7'b0101010;
    run(27);

    // Latch-edge race: change coluna1 with cnt==7, idx==4
    col_in[0] = 7'b0000000;
    run(1);
    chk("race_tick", 16'(frame_tick), 16'h0001);
    run(3);
    chk("race_lin", 16'(linhas), 16'h0000);
    chk("race_col", 16'(colunas), 16'h0001);

    // en control during column 3 ON
    run(17);
    chk("en_pre_col", 16'(colunas), 16'h0004);
    en        = 1'b0;
    col_in[0] = 7'b1010101;
    run(1);
    chk("en_low_blank", 16'(colunas), 16'h0000);
    run(4);
    chk("en_low_tick", 16'(frame_tick), 16'h0000);
    en = 1'b1;
    run(2);
    chk("en_restart_blank", 16'(colunas), 16'h0000);
    run(1);
    chk("en_restart_col", 16'(colunas), 16'h0001);
    chk("en_restart_lin", 16'(linhas), 16'h0055);
    run(1);

    // Asynchronous reset pulse between edges, mid-ON
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_linhas", 16'(linhas), 16'h007F);
    chk("async_colunas", 16'(colunas), 16'h0000);
    chk("async_tick", 16'(frame_tick), 16'h0000);
    run(2);
    reset_n = 1'b1;
    run(43);
    chk("post_rst_col", 16'(colunas), 16'h0001);
    chk("post_rst_lin", 16'(linhas), 16'h0055);
    run(2);

    @(negedge clk);
    #1;
    chk("sb_drained", 16'(sb.size()), 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
